// File: rtl/psram_line_fetcher.sv
// -----------------------------------------------------------------------------
// psram_line_fetcher
//
// Fetches one line of WORDS_PER_LINE 64-bit words from a PSRAM controller and
// writes it into a line buffer. The line is split into WORDS_PER_LINE/4 read
// bursts. Each burst is one cmd_en strobe followed by four rd_data_valid beats.
// Successive commands are spaced by at least CMD_GAP cycles. All outputs are
// registered.
//
// Ports
//   clk             in   single clock, rising edge
//   reset           in   synchronous active-high reset
//   line_start      in   one-cycle request to fetch a line
//   line_base_addr  in   PSRAM address of word 0, sampled with line_start
//   init_calib      in   PSRAM interface ready
//   cmd             out  command type, always read (0)
//   cmd_en          out  one-cycle command strobe
//   addr            out  command address
//   wr_data         out  tied to 0 (reads only)
//   data_mask       out  tied to 0 (reads only)
//   rd_data         in   read beat data
//   rd_data_valid   in   read beat strobe
//   buf_we          out  line-buffer write enable
//   buf_waddr       out  line-buffer word index
//   buf_wdata       out  line-buffer write data
//   busy            out  line fetch in progress
//   done            out  one-cycle pulse when the line is complete
//   overrun         out  one-cycle pulse when a line_start was rejected
// -----------------------------------------------------------------------------
module psram_line_fetcher #(
  parameter int WORDS_PER_LINE  = 40,
  parameter int BURST_ADDR_STEP = 16,
  parameter int CMD_GAP         = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [20:0] line_base_addr,
  input  logic        init_calib,
  output logic        cmd,
  output logic        cmd_en,
  output logic [20:0] addr,
  output logic [63:0] wr_data,
  output logic [7:0]  data_mask,
  input  logic [63:0] rd_data,
  input  logic        rd_data_valid,
  output logic        buf_we,
  output logic [7:0]  buf_waddr,
  output logic [63:0] buf_wdata,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int NUM_BURSTS = WORDS_PER_LINE / 4;
  // The gap counter saturates at CMD_GAP-1, so it only needs to hold that value.
  localparam int GAP_W = (CMD_GAP < 2) ? 1 : $clog2(CMD_GAP);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(CMD_GAP - 1);
  localparam logic [7:0]       LAST_BURST = 8'(NUM_BURSTS - 1);
  localparam logic [20:0]      ADDR_STEP  = 21'(BURST_ADDR_STEP);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    COLLECT = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t            state_r,     state_s;
  logic [7:0]        burst_idx_r, burst_idx_s;
  logic [7:0]        word_idx_r,  word_idx_s;
  logic [2:0]        beat_cnt_r,  beat_cnt_s;
  logic [GAP_W-1:0]  gap_r,       gap_s;
  logic              cmd_en_r,    cmd_en_s;
  logic [20:0]       addr_r,      addr_s;
  logic              buf_we_r,    buf_we_s;
  logic [7:0]        buf_waddr_r, buf_waddr_s;
  logic [63:0]       buf_wdata_r, buf_wdata_s;
  logic              busy_r,      busy_s;
  logic              done_r,      done_s;
  logic              overrun_r,   overrun_s;

  // Next-state and next-output logic; every register gets a hold/idle default.
  always_comb begin
    state_s     = state_r;
    burst_idx_s = burst_idx_r;
    word_idx_s  = word_idx_r;
    beat_cnt_s  = beat_cnt_r;
    gap_s       = gap_r;
    cmd_en_s    = 1'b0;
    addr_s      = addr_r;
    buf_we_s    = 1'b0;
    buf_waddr_s = buf_waddr_r;
    buf_wdata_s = buf_wdata_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    overrun_s   = 1'b0;

    // Any request that is not an accepted start in IDLE is reported as overrun.
    if (line_start && !((state_r == IDLE) && init_calib)) begin
      overrun_s = 1'b1;
    end else begin
      overrun_s = 1'b0;
    end

    case (state_r)
      IDLE: begin
        if (line_start && init_calib) begin
          state_s     = ISSUE;
          burst_idx_s = 8'd0;
          word_idx_s  = 8'd0;
          beat_cnt_s  = 3'd0;
          busy_s      = 1'b1;
          // cmd_en/addr are registered, so they are set on the edge into ISSUE.
          cmd_en_s    = 1'b1;
          addr_s      = line_base_addr;
        end else begin
          state_s = IDLE;
        end
      end

      ISSUE: begin
        state_s = COLLECT;
        gap_s   = '0;
      end

      COLLECT: begin
        if (rd_data_valid && (beat_cnt_r < 3'd4)) begin
          buf_we_s    = 1'b1;
          buf_waddr_s = word_idx_r;
          buf_wdata_s = rd_data;
          word_idx_s  = word_idx_r + 8'd1;
          beat_cnt_s  = beat_cnt_r + 3'd1;
        end else begin
          buf_we_s = 1'b0;
        end

        if (gap_r < GAP_LAST) begin
          gap_s = gap_r + {{(GAP_W-1){1'b0}}, 1'b1};
        end else begin
          gap_s = gap_r;
        end

        if ((beat_cnt_r == 3'd4) && (gap_r >= GAP_LAST)) begin
          if (burst_idx_r == LAST_BURST) begin
            state_s = FINISH;
            done_s  = 1'b1;
          end else begin
            state_s     = ISSUE;
            burst_idx_s = burst_idx_r + 8'd1;
            beat_cnt_s  = 3'd0;
            cmd_en_s    = 1'b1;
            // Stepping the previous address equals base + index*step mod 2^21.
            addr_s      = addr_r + ADDR_STEP;
          end
        end else begin
          state_s = COLLECT;
        end
      end

      FINISH: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end

      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      burst_idx_r <= 8'd0;
      word_idx_r  <= 8'd0;
      beat_cnt_r  <= 3'd0;
      gap_r       <= '0;
      cmd_en_r    <= 1'b0;
      addr_r      <= 21'd0;
      buf_we_r    <= 1'b0;
      buf_waddr_r <= 8'd0;
      buf_wdata_r <= 64'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      burst_idx_r <= burst_idx_s;
      word_idx_r  <= word_idx_s;
      beat_cnt_r  <= beat_cnt_s;
      gap_r       <= gap_s;
      cmd_en_r    <= cmd_en_s;
      addr_r      <= addr_s;
      buf_we_r    <= buf_we_s;
      buf_waddr_r <= buf_waddr_s;
      buf_wdata_r <= buf_wdata_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      overrun_r   <= overrun_s;
    end
  end

  assign cmd       = 1'b0;
  assign wr_data   = 64'd0;
  assign data_mask = 8'd0;
  assign cmd_en    = cmd_en_r;
  assign addr      = addr_r;
  assign buf_we    = buf_we_r;
  assign buf_waddr = buf_waddr_r;
  assign buf_wdata = buf_wdata_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_psram_line_fetcher.sv
// -----------------------------------------------------------------------------
// tb_psram_line_fetcher
//
// Directed bench for psram_line_fetcher with WORDS_PER_LINE=8. A PSRAM
// responder answers each command with beats 9..12 cycles later. A reference
// model holds the expected command addresses and buffer writes in queues, and
// one compare process checks every DUT output on every cycle at the falling
// edge. Literal expectations pin a few model results.
// -----------------------------------------------------------------------------
module tb_psram_line_fetcher;

  localparam int WPL  = 8;
  localparam int STEP = 16;
  localparam int GAP  = 16;
  localparam int NB   = WPL / 4;

  logic        clk = 1'b0;
  logic        reset, line_start, init_calib, rd_data_valid;
  logic [20:0] line_base_addr;
  logic [63:0] rd_data;
  logic        cmd, cmd_en, buf_we, busy, done, overrun;
  logic [20:0] addr;
  logic [63:0] wr_data, buf_wdata;
  logic [7:0]  data_mask, buf_waddr;

  psram_line_fetcher #(.WORDS_PER_LINE(WPL), .BURST_ADDR_STEP(STEP), .CMD_GAP(GAP)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .line_base_addr(line_base_addr),
    .init_calib(init_calib), .cmd(cmd), .cmd_en(cmd_en), .addr(addr), .wr_data(wr_data),
    .data_mask(data_mask), .rd_data(rd_data), .rd_data_valid(rd_data_valid), .buf_we(buf_we),
    .buf_waddr(buf_waddr), .buf_wdata(buf_wdata), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [7:0] waddr; logic [63:0] data; } wr_t;
  typedef struct { int cyc; logic [63:0] data; bit exp; } beat_t;

  wr_t         exp_wr_q[$];
  logic [20:0] exp_addr_q[$];
  beat_t       beat_q[$];

  int  n_checks = 0, n_errors = 0;
  bit  chk_on = 1'b0, line_active = 1'b0, first_pending = 1'b0;
  bit  extra5 = 1'b0, stray_req = 1'b0;
  int  accept_cyc = 0, exp_first_cmd_cyc = 0, last_cmd_cyc = 0, exp_ovr_cyc = -10;
  int  model_word = 0, n_cmd_line = 0, n_wr_line = 0, done_line = 0;
  logic [20:0] cmd_log [8];
  logic [7:0]  wr_log_addr [16];
  logic [63:0] wr_log_data [16];

  task automatic check_val(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_bit(string name, logic got, logic exp);
    check_val(name, 64'(got), 64'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat_data(logic [20:0] a, int i);
    return {11'd0, a, 24'h5A5A00, 8'(i)};
  endfunction

  task automatic check_reset_vals(string tag);
    check_bit({tag, "_cmd_en"}, cmd_en, 1'b0);
    check_bit({tag, "_buf_we"}, buf_we, 1'b0);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_done"}, done, 1'b0);
    check_bit({tag, "_overrun"}, overrun, 1'b0);
    check_val({tag, "_addr"}, 64'(addr), 64'h0);
    check_val({tag, "_buf_waddr"}, 64'(buf_waddr), 64'h0);
    check_bit({tag, "_cmd"}, cmd, 1'b0);
    check_val({tag, "_wr_data"}, wr_data, 64'h0);
    check_val({tag, "_data_mask"}, 64'(data_mask), 64'h0);
  endtask

  // Model of a request: accepted lines expect NB commands at base + b*STEP.
  task automatic start_line(logic [20:0] base, bit acc);
    line_start     = 1'b1;
    line_base_addr = base;
    if (acc) begin
      line_active       = 1'b1;
      accept_cyc        = cyc;
      exp_first_cmd_cyc = cyc + 1;
      first_pending     = 1'b1;
      model_word        = 0;
      n_cmd_line        = 0;
      n_wr_line         = 0;
      done_line         = 0;
      for (int b = 0; b < NB; b++) exp_addr_q.push_back(21'(base + b * STEP));
    end else begin
      exp_ovr_cyc = cyc + 1;
    end
    tick();
    line_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    line_active   = 1'b0;
    first_pending = 1'b0;
    exp_addr_q.delete();
    exp_wr_q.delete();
    @(negedge clk);
    check_reset_vals("rst_mid");
    tick();
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (line_active && n < budget) begin
      tick();
      n++;
    end
    if (line_active) begin
      check_bit("done_timeout", line_active, 1'b0);
      line_active = 1'b0;
      exp_addr_q.delete();
      exp_wr_q.delete();
    end
  endtask

  task automatic line_summary(string tag, int exp_cmds, int exp_wrs, int exp_dones);
    check_val({tag, "_ncmd"}, 64'(n_cmd_line), 64'(exp_cmds));
    check_val({tag, "_nwr"}, 64'(n_wr_line), 64'(exp_wrs));
    check_val({tag, "_ndone"}, 64'(done_line), 64'(exp_dones));
    for (int i = 0; i < exp_wrs && i < 16; i++)
      check_val({tag, "_worder"}, 64'(wr_log_addr[i]), 64'(i));
  endtask

  // PSRAM responder: replays scheduled beats, plus one stray beat on request.
  initial begin
    beat_t bt;
    wr_t   w;
    rd_data_valid = 1'b0;
    rd_data       = 64'd0;
    forever begin
      @(posedge clk);
      #2;
      rd_data_valid = 1'b0;
      if (beat_q.size() > 0 && beat_q[0].cyc <= cyc) begin
        bt = beat_q.pop_front();
        rd_data_valid = 1'b1;
        rd_data       = bt.data;
        if (bt.exp && line_active && !reset) begin
          w.cyc   = cyc + 1;
          w.waddr = 8'(model_word);
          w.data  = bt.data;
          exp_wr_q.push_back(w);
          model_word++;
        end
      end else if (stray_req) begin
        rd_data_valid = 1'b1;
        rd_data       = 64'hDEAD_BEEF_0000_0001;
        stray_req     = 1'b0;
      end
    end
  end

  // Compare process: checks every output against the model each cycle.
  initial begin
    int          c;
    wr_t         w;
    beat_t       bt;
    logic [20:0] ea;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        c = cyc;
        check_bit("overrun", overrun, c == exp_ovr_cyc);
        if (first_pending && c == exp_first_cmd_cyc) begin
          check_bit("first_cmd_time", cmd_en, 1'b1);
          first_pending = 1'b0;
        end
        if (cmd_en) begin
          if (exp_addr_q.size() == 0) begin
            check_bit("cmd_unexpected", cmd_en, 1'b0);
          end else begin
            ea = exp_addr_q.pop_front();
            check_val("cmd_addr", 64'(addr), 64'(ea));
            if (n_cmd_line > 0)
              check_bit("cmd_gap", (c - last_cmd_cyc >= GAP) && (c - last_cmd_cyc <= GAP + 2), 1'b1);
          end
          check_bit("cmd_is_read", cmd, 1'b0);
          if (n_cmd_line < 8) cmd_log[n_cmd_line] = addr;
          n_cmd_line++;
          last_cmd_cyc = c;
          for (int i = 0; i < (extra5 ? 5 : 4); i++) begin
            bt.cyc  = c + 9 + i;
            bt.data = beat_data(addr, i);
            bt.exp  = (i < 4);
            beat_q.push_back(bt);
          end
        end
        if (exp_wr_q.size() > 0 && exp_wr_q[0].cyc == c) begin
          w = exp_wr_q.pop_front();
          check_bit("buf_we", buf_we, 1'b1);
          check_val("buf_waddr", 64'(buf_waddr), 64'(w.waddr));
          check_val("buf_wdata", buf_wdata, w.data);
        end else begin
          check_bit("buf_we_quiet", buf_we, 1'b0);
        end
        if (buf_we) begin
          if (n_wr_line < 16) begin
            wr_log_addr[n_wr_line] = buf_waddr;
            wr_log_data[n_wr_line] = buf_wdata;
          end
          n_wr_line++;
        end
        if (done) begin
          check_bit("done_expected", line_active, 1'b1);
          check_val("done_wr_left", 64'(exp_wr_q.size()), 64'h0);
          check_val("done_cmd_left", 64'(exp_addr_q.size()), 64'h0);
          check_bit("done_busy", busy, 1'b1);
          check_bit("done_time", (c - last_cmd_cyc >= GAP) && (c - last_cmd_cyc <= GAP + 3), 1'b1);
          line_active = 1'b0;
          done_line++;
        end else if (line_active) begin
          check_bit("busy_line", busy, c > accept_cyc);
        end else begin
          check_bit("busy_idle", busy, 1'b0);
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    reset          = 1'b1;
    line_start     = 1'b0;
    line_base_addr = 21'd0;
    init_calib     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_init");
    chk_on = 1'b1;
    tick();

    // Basic 8-word line at 0x00100.
    start_line(21'h00100, 1'b1);
    wait_done(300);
    repeat (4) tick();
    line_summary("basic", 2, 8, 1);
    check_val("basic_addr0", 64'(cmd_log[0]), 64'h00100);
    check_val("basic_addr1", 64'(cmd_log[1]), 64'h00110);
    check_val("basic_w0", wr_log_data[0], 64'h00000100_5A5A0000);
    check_val("basic_w5", wr_log_data[5], 64'h00000110_5A5A0001);

    // Stray beat while idle.
    stray_req = 1'b1;
    repeat (5) tick();

    // Request while the interface is not calibrated.
    init_calib = 1'b0;
    start_line(21'h00200, 1'b0);
    init_calib = 1'b1;
    repeat (20) tick();

    // Repeated request three cycles into a fetch.
    start_line(21'h00300, 1'b1);
    tick();
    tick();
    start_line(21'h00400, 1'b0);
    wait_done(300);
    repeat (4) tick();
    line_summary("rerq", 2, 8, 1);
    check_val("rerq_addr1", 64'(cmd_log[1]), 64'h00310);

    // Address wrap, with a fifth beat per burst that must be dropped.
    extra5 = 1'b1;
    start_line(21'h1FFFF8, 1'b1);
    wait_done(300);
    repeat (4) tick();
    extra5 = 1'b0;
    line_summary("wrap", 2, 8, 1);
    check_val("wrap_addr0", 64'(cmd_log[0]), 64'h1FFFF8);
    check_val("wrap_addr1", 64'(cmd_log[1]), 64'h000008);
    check_val("wrap_w7", wr_log_data[7], 64'h00000008_5A5A0003);
    repeat (6) tick();

    // Reset between beat 2 and beat 3 of burst 0.
    start_line(21'h00500, 1'b1);
    repeat (11) tick();
    do_reset();
    repeat (6) tick();
    check_val("abort_nwr", 64'(n_wr_line), 64'd2);
    check_val("abort_ndone", 64'(done_line), 64'd0);

    // Normal fetch after the abort starts again at word 0.
    start_line(21'h00600, 1'b1);
    wait_done(300);
    repeat (4) tick();
    line_summary("post", 2, 8, 1);
    check_val("post_w0", wr_log_data[0], 64'h00000600_5A5A0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
